switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 6, as the number of switch channels.
REQ-002 The block SHALL take parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), as the stable-level hold time in clocks, legal range 2..2^20-1.
REQ-003 The block SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-004 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-005 RESET_N  input  1  synchronous active-low reset.
REQ-006 SW  input  WIDTH  raw asynchronous slide-switch levels.
REQ-007 SW_DB  output  WIDTH  debounced switch levels, feeds the LED/7-segment display stage directly.
REQ-008 SW_RISE  output  WIDTH  one-cycle pulse per channel on debounced 0->1.
REQ-009 SW_FALL  output  WIDTH  one-cycle pulse per channel on debounced 1->0.
REQ-010 SW_CHANGED  output  1  registered OR of all SW_RISE and SW_FALL bits in the same cycle.

Function
REQ-011 Each SW bit SHALL pass through a 2-flop synchronizer; only the second flop output (s) SHALL drive channel logic.
REQ-012 Each channel SHALL run an independent FSM with states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW and a 20-bit counter.
REQ-013 STABLE_LOW: s=1 -> WAIT_HIGH with counter cleared to 0; else hold.
REQ-014 WAIT_HIGH: s=0 -> STABLE_LOW (glitch rejected, no pulse); s=1 and counter=DEBOUNCE_CYCLES-1 -> STABLE_HIGH; otherwise counter increments by 1.
REQ-015 STABLE_HIGH and WAIT_LOW SHALL mirror REQ-013/014 with levels inverted.
REQ-016 SW_DB bit SHALL be 1 exactly when its channel is in STABLE_HIGH or WAIT_LOW, registered.
REQ-017 SW_DB SHALL change exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples a new SW level, given SW held steady.
REQ-018 SW_RISE/SW_FALL SHALL assert for exactly one cycle, in the same cycle SW_DB changes; never both for one channel in one cycle.
REQ-019 SW_CHANGED SHALL assert in the same cycle as any SW_RISE/SW_FALL bit; multiple channels changing together SHALL produce one cycle of SW_CHANGED.
REQ-020 Any bounce that returns to the old level before counter reaches DEBOUNCE_CYCLES-1 SHALL restart the wait from 0 on the next qualifying edge.
REQ-021 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around.
REQ-022 Channels SHALL not interact; simultaneous transitions on all channels SHALL be handled in parallel with identical latency.

Reset
REQ-023 RESET_N=0 at a rising edge SHALL set synchronizers to 0, all FSMs to STABLE_LOW, counters to 0, SW_DB/SW_RISE/SW_FALL/SW_CHANGED to 0.
REQ-024 Reset during WAIT_* SHALL abort the wait with no pulse emitted.
REQ-025 A switch held high through reset release SHALL produce SW_DB=1 and one SW_RISE pulse DEBOUNCE_CYCLES+3 edges after release.

Structure
REQ-026 State encodings (2-bit), default DEBOUNCE_CYCLES, and counter width SHALL reside in a shared package/header.
REQ-027 Per-channel logic SHALL be one sub-module, debounce_channel, instantiated WIDTH times via generate; top level holds only the SW_CHANGED OR-reduction register.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset, SW=6'b000000 held -> SW_DB=0, no pulses for 20 cycles.
REQ-029 SW[0] 0->1 held -> SW_DB=6'b000001 and SW_RISE[0]=1, SW_CHANGED=1 for one cycle exactly 7 edges later.
REQ-030 SW[2] high for 3 cycles then low -> SW_DB[2] stays 0, no pulses.
REQ-031 SW=6'b111111 applied at once -> SW_DB=6'b111111, SW_RISE=6'b111111, single-cycle SW_CHANGED after 7 edges; then SW=0 -> SW_FALL=6'b111111 after 7 edges.
REQ-032 SW[5] high, RESET_N low 1 cycle during WAIT_HIGH -> no pulse; SW_RISE[5] 7 edges after reset release.
REQ-033 SW[1] toggled every 2 cycles for 30 cycles then held 1 -> exactly one SW_RISE[1], 7 edges after final hold begins.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the switch debouncer: channel FSM encoding,
// counter width and the default hold time.
package switch_debouncer_pkg;

    localparam int CNT_W                   = 20;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        WAIT_LOW    = 2'b11
    } db_state_t;

    // Debounced level implied by a channel state.
    function automatic logic state_level(input db_state_t st);
        return (st == STABLE_HIGH) || (st == WAIT_LOW);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch channel: 2-flop synchronizer, four-state hold FSM,
// registered level and one-cycle edge pulses.
module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic toggle_next,
    output logic [1:0] state
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    db_state_t        st;
    logic [CNT_W-1:0] count;
    logic             level_next;

    // The pulse is emitted in the same cycle db takes its new value, so the
    // top level can register its OR from toggle_next to line up with it.
    always_comb begin
        level_next  = state_level(st);
        toggle_next = level_next ^ db;
        state       = st;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            st    <= STABLE_LOW;
            count <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db    <= level_next;
            rise  <= level_next & ~db;
            fall  <= ~level_next & db;
            case (st)
                STABLE_LOW: begin
                    if (sync2) begin
                        st    <= WAIT_HIGH;
                        count <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2) begin
                        st    <= STABLE_LOW;
                        count <= '0;
                    end else if (count == LAST) begin
                        st    <= STABLE_HIGH;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync2) begin
                        st    <= WAIT_LOW;
                        count <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync2) begin
                        st    <= STABLE_HIGH;
                        count <= '0;
                    end else if (count == LAST) begin
                        st    <= STABLE_LOW;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    st    <= STABLE_LOW;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel slide-switch debouncer: one debounce_channel per switch and a
// single registered "any channel changed" flag.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] SW_DB,
    output logic [WIDTH-1:0] SW_RISE,
    output logic [WIDTH-1:0] SW_FALL,
    output logic             SW_CHANGED,
    output logic [2*WIDTH-1:0] chan_state
);

    logic [WIDTH-1:0] toggle_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk        (CLOCK_50),
            .rst_n      (RESET_N),
            .raw        (SW[i]),
            .db         (SW_DB[i]),
            .rise       (SW_RISE[i]),
            .fall       (SW_FALL[i]),
            .toggle_next(toggle_next[i]),
            .state      (chan_state[2*i +: 2])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            SW_CHANGED <= 1'b0;
        end else begin
            SW_CHANGED <= |toggle_next;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=4, checked every
// cycle against a run-length model of the debounce rule.
module tb_switch_debouncer;

    localparam int W = 6;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic [W-1:0] sw_db, sw_rise, sw_fall;
    logic         sw_changed;
    logic [2*W-1:0] chan_state;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .SW        (sw),
        .SW_DB     (sw_db),
        .SW_RISE   (sw_rise),
        .SW_FALL   (sw_fall),
        .SW_CHANGED(sw_changed),
        .chan_state(chan_state)
    );

    always #5 clk = ~clk;

    // Model: a channel's level flips once the synchronized input has
    // disagreed with it for D+1 consecutive edges; outputs lag one register.
    logic [W-1:0] m_s1, m_s2, m_lvl, m_db, m_rise, m_fall, db_new;
    logic         m_chg;
    int           m_run [W];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_db = '0;
            m_rise = '0; m_fall = '0; m_chg = 1'b0;
            for (int ch = 0; ch < W; ch++) m_run[ch] = 0;
        end else begin
            db_new = m_lvl;
            m_rise = db_new & ~m_db;
            m_fall = ~db_new & m_db;
            m_chg  = |(m_rise | m_fall);
            m_db   = db_new;
            for (int ch = 0; ch < W; ch++) begin
                if (m_s2[ch] != m_lvl[ch]) begin
                    m_run[ch] = m_run[ch] + 1;
                    if (m_run[ch] == D + 1) begin
                        m_lvl[ch] = ~m_lvl[ch];
                        m_run[ch] = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = sw;
        end
    end

    // Pulse counters on DUT outputs, used only as deltas around windows.
    int rise_cnt [W];
    int fall_cnt [W];
    int chg_cnt = 0;
    initial for (int ch = 0; ch < W; ch++) begin rise_cnt[ch] = 0; fall_cnt[ch] = 0; end

    always @(negedge clk) begin
        if (check_en) begin
            for (int ch = 0; ch < W; ch++) begin
                if (sw_rise[ch]) rise_cnt[ch] = rise_cnt[ch] + 1;
                if (sw_fall[ch]) fall_cnt[ch] = fall_cnt[ch] + 1;
            end
            if (sw_changed) chg_cnt = chg_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("model_db",      32'(sw_db),      32'(m_db));
            check("model_rise",    32'(sw_rise),    32'(m_rise));
            check("model_fall",    32'(sw_fall),    32'(m_fall));
            check("model_changed", 32'(sw_changed), 32'(m_chg));
            check("rise_fall_excl", 32'(sw_rise & sw_fall), 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int r0, f0, c0;

    initial begin
        rst_n = 1'b0;
        sw    = '0;
        step(3);
        check("reset_db",      32'(sw_db),      32'd0);
        check("reset_rise",    32'(sw_rise),    32'd0);
        check("reset_fall",    32'(sw_fall),    32'd0);
        check("reset_changed", 32'(sw_changed), 32'd0);
        rst_n    = 1'b1;
        check_en = 1'b1;

        // Idle for 20 cycles: nothing moves.
        c0 = chg_cnt;
        step(20);
        check("idle_db",     32'(sw_db),      32'd0);
        check("idle_pulses", 32'(chg_cnt - c0), 32'd0);

        // Single channel rise lands exactly 7 edges later.
        sw[0] = 1'b1;
        step(7);
        check("ch0_db_before", 32'(sw_db), 32'd0);
        step(1);
        check("ch0_db",      32'(sw_db),      32'h01);
        check("ch0_rise",    32'(sw_rise),    32'h01);
        check("ch0_changed", 32'(sw_changed), 32'd1);
        step(1);
        check("ch0_rise_one_cycle",    32'(sw_rise),    32'd0);
        check("ch0_changed_one_cycle", 32'(sw_changed), 32'd0);
        sw[0] = 1'b0;
        step(8);
        check("ch0_fall", 32'(sw_fall), 32'h01);
        step(4);

        // Short pulses: 3 and 4 cycles rejected, 5 cycles is the shortest accepted.
        r0 = rise_cnt[2];
        sw[2] = 1'b1; step(3); sw[2] = 1'b0; step(15);
        check("glitch3_db",   32'(sw_db),            32'd0);
        check("glitch3_rise", 32'(rise_cnt[2] - r0), 32'd0);
        r0 = rise_cnt[3];
        sw[3] = 1'b1; step(4); sw[3] = 1'b0; step(15);
        check("glitch4_rise", 32'(rise_cnt[3] - r0), 32'd0);
        r0 = rise_cnt[3]; f0 = fall_cnt[3];
        sw[3] = 1'b1; step(5); sw[3] = 1'b0; step(15);
        check("pulse5_rise", 32'(rise_cnt[3] - r0), 32'd1);
        check("pulse5_fall", 32'(fall_cnt[3] - f0), 32'd1);

        // All channels together: parallel, one SW_CHANGED cycle each way.
        c0 = chg_cnt;
        sw = 6'h3f;
        step(7);
        check("all_db_before", 32'(sw_db), 32'd0);
        step(1);
        check("all_db",      32'(sw_db),      32'h3f);
        check("all_rise",    32'(sw_rise),    32'h3f);
        check("all_changed", 32'(sw_changed), 32'd1);
        step(2);
        check("all_changed_once", 32'(chg_cnt - c0), 32'd1);
        sw = 6'h00;
        step(8);
        check("all_fall", 32'(sw_fall), 32'h3f);
        check("all_db_low", 32'(sw_db), 32'd0);
        step(5);
        check("all_changed_twice", 32'(chg_cnt - c0), 32'd2);

        // Reset in the middle of WAIT_HIGH aborts; rise counted from release.
        r0 = rise_cnt[5];
        sw[5] = 1'b1;
        step(4);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(7);
        check("rst_wait_no_rise", 32'(rise_cnt[5] - r0), 32'd0);
        check("rst_wait_db",      32'(sw_db),            32'd0);
        step(1);
        check("rst_release_rise", 32'(sw_rise), 32'h20);
        check("rst_release_db",   32'(sw_db),   32'h20);
        step(3);

        // Chatter on SW[1] every 2 cycles, then a steady high.
        r0 = rise_cnt[1];
        for (int i = 0; i < 14; i++) begin
            sw[1] = ~sw[1];
            step(2);
        end
        sw[1] = 1'b1;
        step(7);
        check("chatter_no_rise", 32'(rise_cnt[1] - r0), 32'd0);
        step(1);
        check("chatter_rise", 32'(sw_rise), 32'h02);
        step(6);
        check("chatter_one_rise", 32'(rise_cnt[1] - r0), 32'd1);
        check("final_db",         32'(sw_db),            32'h22);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
